sram_ctrl: RTL
==============

# sram_ctrl

Synchronous initiator for the team's 8K×8 asynchronous SRAM (13-bit address, chip selects cs1_n/cs2, we_n, oe_n, bidirectional 8-bit data). It converts a single-clock valid/ready request interface into glitch-free, registered SRAM pin sequences with programmable access wait states. Read data returns on a one-cycle response strobe. It sits between on-chip logic (CPU bus bridge, DMA) and the SRAM pins.

## Interface
- AW, 13, SRAM address width
- DW, 8, SRAM data width
- WAIT_CYC, 2, strobe-active cycles per access (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle pulse: read data valid
- rsp_rdata  out  DW  read data, held until next read completes
- cs1_n  out  1  chip select, active low
- cs2  out  1  chip select, active high
- we_n  out  1  write strobe, active low
- oe_n  out  1  output enable, active low
- A  out  AW  SRAM address
- io  inout  DW  SRAM data bus; driven only during write sequences

## Operation
- Request accepted on a rising edge with req_valid && req_ready; req_addr, req_we, req_wdata captured into internal registers. Inputs ignored otherwise.
- req_ready = 1 only in IDLE.
- FSM states: IDLE, SETUP, STROBE, HOLD (plus TURN, see Configuration).
- IDLE: cs1_n=1, cs2=0, we_n=1, oe_n=1, io released. On accept → SETUP.
- SETUP (1 cycle): A driven, cs1_n=0, cs2=1, strobes high; for writes, io driven with captured data. → STROBE.
- STROBE (WAIT_CYC cycles, down-counter): write: we_n=0, oe_n=1; read: oe_n=0, we_n=1. Address, chip selects, and write data stable throughout. Last cycle → HOLD.
- Read capture: io sampled into rsp_rdata on the clock edge ending the last STROBE cycle, before oe_n rises.
- HOLD (1 cycle): strobes high; chip selects, A, and write data held, giving address/data hold after we_n rises. rsp_valid=1 for reads only. → IDLE.
- we_n and oe_n are never low in the same cycle. io is never driven while oe_n=0.
- Every pin output comes directly from a flop: no combinational paths from req_* to pins.

## Timing
- Reset values (asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, cs1_n=1, cs2=0, we_n=1, oe_n=1, A=0, io=Z, wait counter=0.
- Occupancy per access: WAIT_CYC+2 cycles from the accept edge to the return to IDLE. Next accept is possible on the following edge. Throughput is one access per WAIT_CYC+3 cycles.
- Read latency: rsp_valid is high in cycle WAIT_CYC+2 after the accept edge (accept edge = cycle 0).
- req_valid held while req_ready=0: no effect; the request is taken once IDLE is reached.
- Reset asserted mid-access: pins return to reset values immediately (asynchronously). An interrupted write leaves the SRAM word at A undefined. An interrupted read produces no rsp_valid.
- WAIT_CYC=1: STROBE lasts exactly one cycle.

## Configuration
- SRAM_CTRL_TURNAROUND_EN defined: when an accepted write immediately follows a read, the FSM inserts one TURN cycle (all pins idle, io released) before SETUP. Occupancy for that write becomes WAIT_CYC+3 cycles. The controller keeps a registered last-access-was-read flag, reset to 0.
- Undefined: no TURN state. Read-then-write goes straight to SETUP.

## Structure
- Shared package sram_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, TURN);
  - default localparams SRAM_AW=13 and SRAM_DW=8.
- Single module, no sub-module. The wait counter and the io tristate (io = drive_en ? wdata_q : 'z) are inline.

## Test plan
- Write 0xA5 to 0x0123, then read 0x0123, with WAIT_CYC=2: we_n low exactly 2 cycles, A=0x0123 stable from SETUP through HOLD; rsp_valid pulses in cycle 4 after accept with rsp_rdata=0xA5.
- Write the boundary addresses 0x0000←0x11 and 0x1FFF←0xEE, then read both back: returns 0x11 and 0xEE; there is no aliasing.
- Hold req_valid continuously with alternating write and read requests: req_ready is low for WAIT_CYC+2 cycles after each accept; we_n and oe_n are never low together; io is Z whenever oe_n=0.
- Assert rst_n low during STROBE of a write to 0x0200: we_n=1, cs1_n=1, cs2=0, io=Z in the same cycle; req_ready=1 after release; no rsp_valid.
- With SRAM_CTRL_TURNAROUND_EN, issue a read of 0x0010 followed by a write to 0x0011: one extra idle cycle appears before SETUP of the write. Without the macro there is no gap.
- WAIT_CYC=1: read of previously written 0x0ABC←0x3C returns 0x3C with rsp_valid in cycle 3.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the 8Kx8 asynchronous SRAM initiator.
//   state_e  : controller sequencer states
//   SRAM_AW  : default SRAM address width
//   SRAM_DW  : default SRAM data width
package sram_ctrl_pkg;

  localparam int SRAM_AW = 13;
  localparam int SRAM_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns a single-clock valid/ready request into registered,
// glitch-free asynchronous SRAM pin sequences (SETUP, WAIT_CYC x STROBE, HOLD).
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we/addr/wdata     request fields, captured on accept
//   rsp_valid/rsp_rdata   one-cycle read-data strobe / held read data
//   cs1_n, cs2, we_n, oe_n, A   SRAM control and address pins (all flops)
//   io                    bidirectional SRAM data, driven only on writes
//
// Optional build macro: SRAM_CTRL_TURNAROUND_EN inserts one idle TURN cycle
// before a write whose preceding accepted access was a read.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW       = SRAM_AW,
  parameter int DW       = SRAM_DW,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          cs1_n,
  output logic          cs2,
  output logic          we_n,
  output logic          oe_n,
  output logic [AW-1:0] A,
  inout  wire  [DW-1:0] io
);

  localparam int            CW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          drive_q, drive_d;
  logic          cs1_n_q, cs1_n_d;
  logic          cs2_q, cs2_d;
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          turn_needed;

`ifdef SRAM_CTRL_TURNAROUND_EN
  // Remembers whether the last accepted access was a read, so a following
  // write gets a bus-turnaround cycle before io is driven.
  logic last_rd_q, last_rd_d;

  always_comb begin
    last_rd_d = last_rd_q;
    if (state_q == IDLE && req_valid) last_rd_d = !req_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_rd_q <= 1'b0;
    else        last_rd_q <= last_rd_d;
  end

  assign turn_needed = req_we && last_rd_q;
`else
  assign turn_needed = 1'b0;
`endif

  // Pin values are computed for the *next* state so every pin is a flop output.
  always_comb begin
    // NOTE: every variable gets a default first, so no branch of the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    cs1_n_d     = 1'b1;
    cs2_d       = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    drive_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          if (turn_needed) begin
            state_d = TURN;
          end else begin
            state_d = SETUP;
            cs1_n_d = 1'b0;
            cs2_d   = 1'b1;
            drive_d = req_we;
          end
        end
      end
      TURN: begin
        state_d = SETUP;
        cs1_n_d = 1'b0;
        cs2_d   = 1'b1;
        drive_d = we_q;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
        cs1_n_d = 1'b0;
        cs2_d   = 1'b1;
        drive_d = we_q;
        we_n_d  = !we_q;
        oe_n_d  = we_q;
      end
      STROBE: begin
        cs1_n_d = 1'b0;
        cs2_d   = 1'b1;
        drive_d = we_q;
        if (cnt_q == '0) begin
          // This edge ends the last strobe cycle: oe_n is still low on the
          // pins, so io carries valid SRAM data right now.
          state_d     = HOLD;
          rsp_valid_d = !we_q;
          if (!we_q) rdata_d = io;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          we_n_d = !we_q;
          oe_n_d = we_q;
        end
      end
      HOLD: begin
        // Pins were held active for this cycle by the STROBE exit; now release.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      drive_q     <= 1'b0;
      cs1_n_q     <= 1'b1;
      cs2_q       <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      drive_q     <= drive_d;
      cs1_n_q     <= cs1_n_d;
      cs2_q       <= cs2_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign cs1_n     = cs1_n_q;
  assign cs2       = cs2_q;
  assign we_n      = we_n_q;
  assign oe_n      = oe_n_q;
  assign A         = addr_q;
  assign io        = drive_q ? wdata_q : 'z;

endmodule
